// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Grants are combinational, responses return one cycle later in grant order.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_resp_valid;
  logic             r_resp_data;
  logic             r_resp_wr;

  logic w_starved;
  logic w_data_win;
  logic w_inst_win;
  logic w_data_grant;
  logic w_inst_grant;

  // Data normally wins; a pending fetch that has lost STARVE_LIMIT times in a row takes the slot.
  assign w_starved  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_data_win = data_req & ~(inst_req & w_starved);
  assign w_inst_win = inst_req & ~w_data_win;

  // Outputs are forced quiet while reset is asserted; the flops are held in reset anyway.
  assign w_data_grant = resetn & w_data_win;
  assign w_inst_grant = resetn & w_inst_win;

  assign data_addr_ok = w_data_grant;
  assign inst_addr_ok = w_inst_grant;

  assign sram_en    = w_data_grant | w_inst_grant;
  assign sram_we    = (w_data_grant & data_wr) ? data_wstrb : 4'b0000;
  assign sram_addr  = w_data_grant ? data_addr :
                      w_inst_grant ? inst_addr : '0;
  assign sram_wdata = w_data_grant ? data_wdata : 32'h0;

  assign inst_data_ok = r_resp_valid & ~r_resp_data;
  assign data_data_ok = r_resp_valid &  r_resp_data;
  assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
  assign data_rdata   = (data_data_ok & ~r_resp_wr) ? sram_rdata : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= 1'b0;
      r_resp_wr    <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_resp_valid <= w_data_win | w_inst_win;
      r_resp_data  <= w_data_win;
      r_resp_wr    <= w_data_win & data_wr;
      if (!inst_req || w_inst_win) begin
        r_starve_cnt <= '0;
      end else if (w_data_win && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: inputs change on the falling edge,
// grants are sampled just after, responses just after the following rising edge.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  sram_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    inst_req   = 1'b0;
    inst_addr  = 32'h0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    sram_rdata = 32'h0;
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h80; data_wdata = 32'h12345678; inst_addr = 32'h40;
    @(negedge clk); #1;
    n_tests++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_hold_neg: outputs=%b required=%b",
               {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we}, 9'b0);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_hold_pos: outputs=%b required=%b",
               {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we}, 9'b0);
    end
    @(negedge clk);
    resetn = 1'b1; data_wr = 1'b0;
    #1;
    n_tests++;
    if ({inst_addr_ok, data_addr_ok, sram_en} !== 3'b011) begin
      n_fail++;
      $display("FAIL reset_release_grant: ia_ok,da_ok,en=%b required=011",
               {inst_addr_ok, data_addr_ok, sram_en});
    end
    @(posedge clk); #1 sram_rdata = 32'hA5A5_0001; #1;
    n_tests++;
    if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL reset_release_resp: id_ok,dd_ok=%b rdata=%h required 01 a5a50001",
               {inst_data_ok, data_data_ok}, data_rdata);
    end
    @(negedge clk); idle_inputs();
    @(posedge clk);
  endtask

  task automatic test_inst_read();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    #1;
    n_tests++;
    if ({inst_addr_ok, data_addr_ok, sram_en, sram_we} !== 7'b1010000 || sram_addr !== 32'h1C00_0000) begin
      n_fail++;
      $display("FAIL inst_read_grant: ok/en/we=%b addr=%h required 1010000 1c000000",
               {inst_addr_ok, data_addr_ok, sram_en, sram_we}, sram_addr);
    end
    @(posedge clk); #1 sram_rdata = 32'h0280_0C0C; #1;
    n_tests++;
    if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h0280_0C0C || data_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL inst_read_resp: id_ok,dd_ok=%b irdata=%h drdata=%h required 10 02800c0c 0",
               {inst_data_ok, data_data_ok}, inst_rdata, data_rdata);
    end
    @(negedge clk); idle_inputs(); #1;
    n_tests++;
    if ({sram_en, sram_we} !== 5'b0 || sram_addr !== 32'h0 || sram_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_sram: en,we=%b addr=%h wdata=%h required all zero",
               {sram_en, sram_we}, sram_addr, sram_wdata);
    end
    @(posedge clk); #2;
    n_tests++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_no_resp: id_ok,dd_ok=%b required 00", {inst_data_ok, data_data_ok});
    end
  endtask

  task automatic test_data_write();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100;
    data_wstrb = 4'h3; data_wdata = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if ({inst_addr_ok, data_addr_ok, sram_en, sram_we} !== 7'b0110011 ||
        sram_addr !== 32'h100 || sram_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL data_write_grant: ok/en/we=%b addr=%h wdata=%h required 0110011 100 deadbeef",
               {inst_addr_ok, data_addr_ok, sram_en, sram_we}, sram_addr, sram_wdata);
    end
    @(posedge clk); #1 sram_rdata = 32'hFFFF_FFFF; #1;
    n_tests++;
    if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h0 || inst_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL data_write_resp: id_ok,dd_ok=%b drdata=%h irdata=%h required 01 0 0",
               {inst_data_ok, data_data_ok}, data_rdata, inst_rdata);
    end
    @(negedge clk); idle_inputs();
    @(posedge clk);
  endtask

  task automatic test_data_read();
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h40; data_wstrb = 4'hF;
    #1;
    n_tests++;
    if ({data_addr_ok, sram_en, sram_we} !== 6'b110000 || sram_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL data_read_grant: ok/en/we=%b addr=%h required 110000 40",
               {data_addr_ok, sram_en, sram_we}, sram_addr);
    end
    @(posedge clk); #1 sram_rdata = 32'hCAFE_F00D; #1;
    n_tests++;
    if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'hCAFE_F00D || inst_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL data_read_resp: id_ok,dd_ok=%b drdata=%h irdata=%h required 01 cafef00d 0",
               {inst_data_ok, data_data_ok}, data_rdata, inst_rdata);
    end
    @(negedge clk); idle_inputs();
    @(posedge clk);
  endtask

  task automatic test_starvation();
    logic exp_inst;
    logic prev_inst;
    logic [31:0] exp_addr;
    prev_inst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
      inst_addr = 32'h1000 + 32'(c * 4);
      data_addr = 32'h2000 + 32'(c * 4);
      exp_inst = (c == 4) || (c == 9);
      exp_addr = exp_inst ? 32'h1000 + 32'(c * 4) : 32'h2000 + 32'(c * 4);
      #1;
      n_tests++;
      if ({inst_addr_ok, data_addr_ok} !== {exp_inst, ~exp_inst} || sram_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL starve_grant_c%0d: ia_ok,da_ok=%b addr=%h required %b %h",
                 c, {inst_addr_ok, data_addr_ok}, sram_addr, {exp_inst, ~exp_inst}, exp_addr);
      end
      if (c > 0) begin
        n_tests++;
        if ({inst_data_ok, data_data_ok} !== {prev_inst, ~prev_inst}) begin
          n_fail++;
          $display("FAIL starve_resp_c%0d: id_ok,dd_ok=%b required %b",
                   c, {inst_data_ok, data_data_ok}, {prev_inst, ~prev_inst});
        end
      end
      prev_inst = exp_inst;
    end
    @(negedge clk); idle_inputs();
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h0;
    @(posedge clk); #1 sram_rdata = 32'h11; #1;
    n_tests++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h11) begin
      n_fail++;
      $display("FAIL b2b_first: id_ok=%b rdata=%h required 1 11", inst_data_ok, inst_rdata);
    end
    @(negedge clk);
    inst_addr = 32'h4;
    #1;
    n_tests++;
    if (inst_addr_ok !== 1'b1 || sram_addr !== 32'h4 || inst_data_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_overlap: ia_ok=%b addr=%h id_ok=%b required 1 4 1",
               inst_addr_ok, sram_addr, inst_data_ok);
    end
    @(posedge clk); #1 sram_rdata = 32'h22; #1;
    n_tests++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h22) begin
      n_fail++;
      $display("FAIL b2b_second: id_ok=%b rdata=%h required 1 22", inst_data_ok, inst_rdata);
    end
    @(negedge clk); idle_inputs();
    @(posedge clk); #2;
    n_tests++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b_end: id_ok=%b rdata=%h required 0 0", inst_data_ok, inst_rdata);
    end
  endtask

  task automatic test_reset_midflight();
    logic exp_inst;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h500; data_req = 1'b1; data_wr = 1'b0;
      data_addr = 32'h300 + 32'(c * 4);
      #1;
      n_tests++;
      if (data_addr_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL midflight_pre_c%0d: da_ok=%b required 1", c, data_addr_ok);
      end
    end
    @(posedge clk); #1 resetn = 1'b0; sram_rdata = 32'h7777_7777; #1;
    n_tests++;
    if ({inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok, sram_en} !== 5'b0 || data_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midflight_in_reset: ok/en=%b drdata=%h required 00000 0",
               {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok, sram_en}, data_rdata);
    end
    @(negedge clk); idle_inputs(); resetn = 1'b1;
    @(posedge clk); #2;
    n_tests++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      n_fail++;
      $display("FAIL midflight_after: id_ok,dd_ok=%b required 00", {inst_data_ok, data_data_ok});
    end
    // A cleared starvation count lets data win four times before fetch is forced in.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
      exp_inst = (c == 4);
      #1;
      n_tests++;
      if ({inst_addr_ok, data_addr_ok} !== {exp_inst, ~exp_inst}) begin
        n_fail++;
        $display("FAIL midflight_starve_c%0d: ia_ok,da_ok=%b required %b",
                 c, {inst_addr_ok, data_addr_ok}, {exp_inst, ~exp_inst});
      end
    end
    @(negedge clk); idle_inputs();
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_data_write();
    test_data_read();
    test_starvation();
    test_back_to_back();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between the CPU's instruction-fetch requester and data-access requester.
- Both requesters use an sram-like req/addr_ok/data_ok handshake.
- Sits between the pipeline core and the unified memory.
- Grants at most one access per cycle, fully pipelined, with fixed 1-cycle response latency and bounded starvation of instruction fetch.

Parameters:
- ADDR_W, 32, address width of requesters and SRAM.
- STARVE_LIMIT, 4, maximum consecutive cycles a pending inst request may lose to data before it is forced to win (must be ≥1).

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction read request (read-only port)
- inst_addr  in  ADDR_W  instruction byte address
- inst_addr_ok  out  1  inst request accepted this cycle
- inst_data_ok  out  1  inst read data valid this cycle
- inst_rdata  out  32  inst read data
- data_req  in  1  data request
- data_wr  in  1  1=write, 0=read
- data_wstrb  in  4  byte write strobes (ignored on read)
- data_addr  in  ADDR_W  data byte address
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response (read data or write completion) this cycle
- data_rdata  out  32  data read data
- sram_en  out  1  SRAM access enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid cycle after sram_en

Behaviour:
- Grant (combinational, cycle T):
  - data_req only -> data wins.
  - inst_req only -> inst wins.
  - Both -> data wins unless starve_cnt == STARVE_LIMIT, then inst wins.
- Winner's addr_ok=1 in T. Loser's addr_ok=0; the requester holds req/addr/wdata stable until its addr_ok.
- sram_en=1 in T iff any grant.
- sram_addr/sram_wdata from winner.
- sram_we = data_wstrb if data write granted, else 4'b0.
- When idle: sram_en=0, sram_we=0, sram_addr/wdata = 0.
- Response registers (set at T, used at T+1): resp_valid, resp_owner (inst/data), resp_wr.
- Cycle T+1 response:
  - Owner's data_ok=1.
  - Inst read: inst_rdata = sram_rdata.
  - Data read: data_rdata = sram_rdata.
  - Data write: data_rdata = 0.
- Non-owner data_ok=0; non-owner rdata = 0.
- Requesters never back-pressure responses.
- Pipelined: a new grant in T+1 is allowed alongside the response for T. Sustained throughput is 1 access/cycle. Responses return in grant order.
- starve_cnt (width ceil(log2(STARVE_LIMIT+1))):
  - Cleared when inst granted or inst_req=0.
  - +1 each cycle inst_req=1 and data granted.
  - Saturates at STARVE_LIMIT.
- Reset (resetn=0, any time, async):
  - resp_valid=0, starve_cnt=0, all addr_ok/data_ok=0.
  - A transaction granted just before reset gets no data_ok.
  - First grant possible in the first cycle after resetn rises.
- No internal state beyond the response registers and starve_cnt; no FSM stall states.

Test Plan:
- Reset: hold resetn=0 with both reqs high -> all addr_ok/data_ok/sram_en/sram_we = 0. Release -> data granted that cycle.
- Inst read alone, inst_addr=0x1C000000, SRAM returns 0x02800C0C -> T: inst_addr_ok=1, sram_en=1, sram_we=0, sram_addr=0x1C000000. T+1: inst_data_ok=1, inst_rdata=0x02800C0C, data_data_ok=0.
- Data write addr=0x100, wstrb=0x3, wdata=0xDEADBEEF -> T: data_addr_ok=1, sram_we=0x3, sram_wdata=0xDEADBEEF. T+1: data_data_ok=1, data_rdata=0.
- Starvation, both reqs held continuously with STARVE_LIMIT=4 -> data granted cycles 0–3, inst granted cycle 4, starve_cnt returns to 0, data granted cycles 5–8, inst again at cycle 9.
- Pipelining: inst reads 0x0 then 0x4 in consecutive cycles, SRAM returns 0x11, 0x22 -> inst_data_ok high two consecutive cycles with 0x11 then 0x22. No bubble.
- Reset mid-flight: grant data read at T, pull resetn low during T+1 -> data_data_ok stays 0, starve_cnt=0, no response after release.
